jogador_automatico: RTL and testbench
=====================================

# jogador_automatico

Automatic player for the `jogo_playseq` memory game: watches the game's `leds` output while a sequence is displayed, stores each shown LED in a small buffer, and replays the stored sequence on the game's `botoes` input. Each press is a timed one-hot pulse followed by a release gap. It sits beside `jogo_playseq` in the board top level, or in a bench, and replaces a human player for hardware demos and long regression runs. One capture/replay pass is made per game round, and the pass repeats until the game ends or the block is disabled.

## Interface
- `MAX_JOGADAS`, 16: buffer depth in entries, each 4 bits.
- `T_PRESS`, 500: cycles each button is held.
- `T_GAP`, 500: cycles of all-released between presses.
- `T_QUIET`, 1500: consecutive cycles of `leds==0` that mark the end of the display phase. Must be greater than the game's inter-LED gap.

- `clock` in 1: single clock; all state changes on the rising edge.
- `reset` in 1: asynchronous, active-high; clears all state and outputs.
- `habilita` in 1: level; low forces OCIOSO.
- `fim_jogo` in 1: game finished (ganhou|perdeu from game); forces OCIOSO.
- `leds` in 4: game LED output, synchronous to `clock`.
- `botoes` out 4: button stimulus to game; registered.
- `jogando` out 1: high in PRESSIONA/SOLTA.
- `tamanho` out clog2(MAX_JOGADAS)+1: number of entries captured this round.
- `erro_padrao` out 1: sticky; a non-one-hot nonzero `leds` pattern was seen.
- `estouro` out 1: sticky; a capture was attempted with the buffer full.
- `db_estado` out 4: current state code.

## Operation
- States and codes: OCIOSO=0, ESPERA_LED=1, ESPERA_APAGAR=2, SILENCIO=3, PRESSIONA=4, SOLTA=5.
- Priority: `reset` > (`fim_jogo` | !`habilita`) > normal transitions.
- OCIOSO: `botoes`=0, `tamanho`=0. Goes to ESPERA_LED when `habilita` && !`fim_jogo`; this entry clears `erro_padrao` and `estouro`.
- ESPERA_LED and SILENCIO, when `leds`!=0:
  - If `leds` is one-hot and `tamanho`<MAX_JOGADAS: write `leds` to mem[`tamanho`] and increment `tamanho`.
  - If one-hot and the buffer is full: set `estouro` and do not write.
  - If not one-hot: set `erro_padrao` and do not write.
  - In all three cases, go to ESPERA_APAGAR.
- ESPERA_APAGAR: wait for `leds`==0, then go to SILENCIO with the quiet counter cleared. The first zero cycle is counted as 1.
- SILENCIO:
  - The quiet counter increments each cycle `leds`==0.
  - When it reaches T_QUIET and `tamanho`>0: go to PRESSIONA with idx=0.
  - When it reaches T_QUIET and `tamanho`==0: the counter saturates and the state holds.
- PRESSIONA: `botoes`=mem[idx] for exactly T_PRESS cycles, then SOLTA.
- SOLTA: `botoes`=0 for exactly T_GAP cycles, then idx++.
  - If idx==`tamanho`: clear `tamanho` and go to ESPERA_LED for the next round.
  - Otherwise go to PRESSIONA.
- `leds` is ignored in PRESSIONA/SOLTA, because the game echoes presses on `leds`.
- Two equal consecutive LEDs are captured only if separated by at least one `leds`==0 cycle. A direct change from one nonzero pattern to another is not recorded as a new entry.

## Timing
- Reset values:
  - `botoes`=0, `jogando`=0, `tamanho`=0, `erro_padrao`=0, `estouro`=0, `db_estado`=0.
  - idx and all counters are 0; buffer contents are don't-care.
- Capture latency: `leds` sampled nonzero at edge k updates `tamanho` and the state after edge k.
- Display-end detection: if `leds` is first sampled 0 at edge k, `botoes` becomes mem[0] after edge k+T_QUIET, and `jogando` rises on the same edge.
- Each press occupies T_PRESS cycles plus T_GAP cycles. A round of N entries ends N·(T_PRESS+T_GAP) cycles after the first press, then the state returns to ESPERA_LED.
- `fim_jogo` or !`habilita` sampled high: `botoes`=0 and `jogando`=0 after that same edge. Asynchronous `reset` clears outputs immediately, mid-press included.
- Counters are wide enough for the maximum of T_PRESS, T_GAP and T_QUIET, with no wrap. idx and `tamanho` never exceed MAX_JOGADAS.

## Test plan
All scenarios use MAX_JOGADAS=4, T_PRESS=3, T_GAP=2, T_QUIET=5.

- Reset mid-PRESSIONA:
  - Response: `botoes`=0 and `db_estado`=0 immediately, with `tamanho`=0.
  - After reset, `habilita`=1 → `db_estado`=1 one cycle later.
- Display 0001, 0010, 0100, each held 2 cycles with 2-cycle gaps, then hold 0:
  - `tamanho`=3.
  - `botoes` shows 0001 (3 cycles), 0 (2), 0010 (3), 0 (2), 0100 (3), 0 (2).
  - Then `db_estado`=1 and `tamanho`=0.
- Display pattern 0011 then 1000:
  - `erro_padrao`=1 and `tamanho`=1.
  - Replay shows only 1000.
- Display five one-hot LEDs: `estouro`=1, `tamanho`=4, and four presses are replayed.
- Assert `fim_jogo` during the second press: `botoes`=0 and `db_estado`=0 on the next edge, with no further presses.
- Display 1000, 0 for 4 cycles, then 1000 again:
  - No replay starts after the 4-cycle gap, because the quiet window is not reached.
  - Result: `tamanho`=2 and two 1000 presses.

Source files
------------

// File: rtl/jogador_automatico.sv
// -----------------------------------------------------------------------------
// jogador_automatico
//
// Automatic player for the jogo_playseq memory game. While the game displays
// its sequence, each one-hot LED pattern seen on `leds` is stored in a small
// buffer. Once `leds` has been quiet for T_QUIET cycles, the stored sequence
// is replayed on `botoes` as timed presses (T_PRESS cycles held, then T_GAP
// cycles released). Then the block waits for the next round's display.
//
// Ports:
//   clock        - single clock, rising edge
//   reset        - asynchronous, active-high; clears all state and outputs
//   habilita     - enable level; low forces the idle state
//   fim_jogo     - game over; forces the idle state
//   leds   [3:0] - LED output of the game (synchronous to clock)
//   botoes [3:0] - registered one-hot button stimulus to the game
//   jogando      - high while replaying (press or release phase)
//   tamanho      - number of entries captured this round
//   erro_padrao  - sticky: a nonzero, non-one-hot LED pattern was seen
//   estouro      - sticky: a capture was attempted with the buffer full
//   db_estado    - current state code, for debug
// -----------------------------------------------------------------------------
module jogador_automatico #(
    parameter int MAX_JOGADAS = 16,
    parameter int T_PRESS     = 500,
    parameter int T_GAP       = 500,
    parameter int T_QUIET     = 1500
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          habilita,
    input  logic                          fim_jogo,
    input  logic [3:0]                    leds,
    output logic [3:0]                    botoes,
    output logic                          jogando,
    output logic [$clog2(MAX_JOGADAS):0]  tamanho,
    output logic                          erro_padrao,
    output logic                          estouro,
    output logic [3:0]                    db_estado
);

    localparam int AW      = $clog2(MAX_JOGADAS);
    localparam int TW      = AW + 1;
    localparam int CNT_MAX = (T_PRESS > T_GAP)
                           ? ((T_PRESS > T_QUIET) ? T_PRESS : T_QUIET)
                           : ((T_GAP   > T_QUIET) ? T_GAP   : T_QUIET);
    localparam int CW      = $clog2(CNT_MAX + 1);

    localparam logic [TW-1:0] MAX_C       = TW'(MAX_JOGADAS);
    localparam logic [TW-1:0] TAM_ZERO    = {TW{1'b0}};
    localparam logic [TW-1:0] TAM_ONE     = {{(TW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0] CNT_ZERO    = {CW{1'b0}};
    localparam logic [CW-1:0] CNT_ONE     = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0] PRESS_END_C = CW'(T_PRESS - 1);
    localparam logic [CW-1:0] GAP_END_C   = CW'(T_GAP - 1);
    localparam logic [CW-1:0] QUIET_C     = CW'(T_QUIET);
    localparam logic [AW-1:0] ADDR_ZERO   = {AW{1'b0}};

    typedef enum logic [3:0] {
        OCIOSO        = 4'd0,
        ESPERA_LED    = 4'd1,
        ESPERA_APAGAR = 4'd2,
        SILENCIO      = 4'd3,
        PRESSIONA     = 4'd4,
        SOLTA         = 4'd5
    } estado_t;

    // Nonzero with exactly one bit set.
    function automatic logic is_one_hot(input logic [3:0] v);
        return (v != 4'b0000) && ((v & (v - 4'b0001)) == 4'b0000);
    endfunction

    estado_t         state_q,   state_d;
    logic [3:0]      botoes_q,  botoes_d;
    logic            jogando_q, jogando_d;
    logic [TW-1:0]   tamanho_q, tamanho_d;
    logic [TW-1:0]   idx_q,     idx_d;
    logic [CW-1:0]   cnt_q,     cnt_d;
    logic            erro_q,    erro_d;
    logic            estouro_q, estouro_d;

    logic            mem_we_s;
    logic [TW-1:0]   idx_inc_s;
    logic [3:0]      mem_q [MAX_JOGADAS];

    assign idx_inc_s = idx_q + TAM_ONE;

    // Next-state and next-output computation for the capture/replay FSM.
    always_comb begin
        state_d   = state_q;
        botoes_d  = botoes_q;
        jogando_d = jogando_q;
        tamanho_d = tamanho_q;
        idx_d     = idx_q;
        cnt_d     = cnt_q;
        erro_d    = erro_q;
        estouro_d = estouro_q;
        mem_we_s  = 1'b0;

        if (fim_jogo || !habilita) begin
            // Abort from any state; sticky flags survive until the next start.
            state_d   = OCIOSO;
            botoes_d  = 4'b0000;
            jogando_d = 1'b0;
            tamanho_d = TAM_ZERO;
            idx_d     = TAM_ZERO;
            cnt_d     = CNT_ZERO;
        end else begin
            case (state_q)
                OCIOSO: begin
                    state_d   = ESPERA_LED;
                    erro_d    = 1'b0;
                    estouro_d = 1'b0;
                    botoes_d  = 4'b0000;
                    tamanho_d = TAM_ZERO;
                end

                ESPERA_LED, SILENCIO: begin
                    if (leds != 4'b0000) begin
                        if (is_one_hot(leds)) begin
                            if (tamanho_q < MAX_C) begin
                                mem_we_s  = 1'b1;
                                tamanho_d = tamanho_q + TAM_ONE;
                            end else begin
                                estouro_d = 1'b1;
                            end
                        end else begin
                            erro_d = 1'b1;
                        end
                        state_d = ESPERA_APAGAR;
                        cnt_d   = CNT_ZERO;
                    end else if (state_q == SILENCIO) begin
                        if (cnt_q >= QUIET_C) begin
                            if (tamanho_q != TAM_ZERO) begin
                                state_d   = PRESSIONA;
                                idx_d     = TAM_ZERO;
                                cnt_d     = CNT_ZERO;
                                botoes_d  = mem_q[ADDR_ZERO];
                                jogando_d = 1'b1;
                            end else begin
                                // Nothing to replay: counter saturates, state holds.
                                cnt_d = cnt_q;
                            end
                        end else begin
                            cnt_d = cnt_q + CNT_ONE;
                        end
                    end else begin
                        state_d = ESPERA_LED;
                    end
                end

                ESPERA_APAGAR: begin
                    if (leds == 4'b0000) begin
                        // This first zero cycle already counts toward the quiet window.
                        state_d = SILENCIO;
                        cnt_d   = CNT_ONE;
                    end else begin
                        state_d = ESPERA_APAGAR;
                    end
                end

                PRESSIONA: begin
                    if (cnt_q >= PRESS_END_C) begin
                        state_d  = SOLTA;
                        botoes_d = 4'b0000;
                        cnt_d    = CNT_ZERO;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end

                SOLTA: begin
                    if (cnt_q >= GAP_END_C) begin
                        cnt_d = CNT_ZERO;
                        if (idx_inc_s >= tamanho_q) begin
                            state_d   = ESPERA_LED;
                            jogando_d = 1'b0;
                            tamanho_d = TAM_ZERO;
                            idx_d     = TAM_ZERO;
                        end else begin
                            state_d  = PRESSIONA;
                            idx_d    = idx_inc_s;
                            botoes_d = mem_q[idx_inc_s[AW-1:0]];
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end

                default: begin
                    state_d   = OCIOSO;
                    botoes_d  = 4'b0000;
                    jogando_d = 1'b0;
                    tamanho_d = TAM_ZERO;
                    idx_d     = TAM_ZERO;
                    cnt_d     = CNT_ZERO;
                end
            endcase
        end
    end

    // FSM state, counters and registered outputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= OCIOSO;
            botoes_q  <= 4'b0000;
            jogando_q <= 1'b0;
            tamanho_q <= TAM_ZERO;
            idx_q     <= TAM_ZERO;
            cnt_q     <= CNT_ZERO;
            erro_q    <= 1'b0;
            estouro_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            botoes_q  <= botoes_d;
            jogando_q <= jogando_d;
            tamanho_q <= tamanho_d;
            idx_q     <= idx_d;
            cnt_q     <= cnt_d;
            erro_q    <= erro_d;
            estouro_q <= estouro_d;
        end
    end

    // Sequence buffer; contents are meaningless until written, so no reset.
    always_ff @(posedge clock) begin
        if (mem_we_s) begin
            mem_q[tamanho_q[AW-1:0]] <= leds;
        end
    end

    assign botoes      = botoes_q;
    assign jogando     = jogando_q;
    assign tamanho     = tamanho_q;
    assign erro_padrao = erro_q;
    assign estouro     = estouro_q;
    assign db_estado   = state_q;

endmodule

// File: tb/tb_jogador_automatico.sv
// -----------------------------------------------------------------------------
// tb_jogador_automatico
//
// Directed bench for jogador_automatico with MAX_JOGADAS=4, T_PRESS=3,
// T_GAP=2, T_QUIET=5. Stimulus pushes the expected replayed buttons into a
// queue; an independent monitor pops one entry at every press start and also
// checks press and gap durations.
// -----------------------------------------------------------------------------
module tb_jogador_automatico;

    localparam int MAXJ  = 4;
    localparam int TP    = 3;
    localparam int TG    = 2;
    localparam int TQ    = 5;
    localparam int LIMIT = 200;

    logic       clock = 1'b0;
    logic       reset;
    logic       habilita;
    logic       fim_jogo;
    logic [3:0] leds;
    logic [3:0] botoes;
    logic       jogando;
    logic [2:0] tamanho;
    logic       erro_padrao;
    logic       estouro;
    logic [3:0] db_estado;

    int n_checks = 0;
    int n_fail   = 0;
    int n_press  = 0;
    logic [3:0] exp_q[$];

    jogador_automatico #(
        .MAX_JOGADAS(MAXJ),
        .T_PRESS    (TP),
        .T_GAP      (TG),
        .T_QUIET    (TQ)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .habilita   (habilita),
        .fim_jogo   (fim_jogo),
        .leds       (leds),
        .botoes     (botoes),
        .jogando    (jogando),
        .tamanho    (tamanho),
        .erro_padrao(erro_padrao),
        .estouro    (estouro),
        .db_estado  (db_estado)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: pops the scoreboard on each press start, times presses and gaps.
    logic [3:0] prev_b = 4'b0000;
    bit         in_press = 1'b0;
    bit         in_gap = 1'b0;
    int         press_len = 0;
    int         gap_len = 0;
    logic [3:0] exp_v;

    always @(negedge clock) begin
        if (botoes != 4'b0000 && prev_b == 4'b0000) begin
            if (in_gap) begin
                chk("gap length", gap_len, TG);
                in_gap = 1'b0;
            end
            n_press++;
            if (exp_q.size() == 0) begin
                chk("unexpected press", {28'd0, botoes}, 32'd0);
            end else begin
                exp_v = exp_q.pop_front();
                chk("press value", {28'd0, botoes}, {28'd0, exp_v});
            end
            in_press  = 1'b1;
            press_len = 1;
        end else if (botoes != 4'b0000) begin
            press_len++;
        end else begin
            if (in_press) begin
                in_press = 1'b0;
                if (jogando) begin
                    chk("press length", press_len, TP);
                    in_gap  = 1'b1;
                    gap_len = 1;
                end
            end else if (in_gap) begin
                if (jogando) begin
                    gap_len++;
                end else begin
                    chk("gap length", gap_len, TG);
                    in_gap = 1'b0;
                end
            end
        end
        prev_b = botoes;
    end

    task automatic cyc(input logic [3:0] v);
        @(negedge clock);
        leds = v;
    endtask

    task automatic restart();
        @(negedge clock);
        habilita = 1'b0;
        leds     = 4'b0000;
        @(negedge clock);
        habilita = 1'b1;
    endtask

    task automatic wait_jogando(input logic lvl, input string name);
        int n = 0;
        while (jogando !== lvl && n < LIMIT) begin
            @(negedge clock);
            n++;
        end
        chk(name, {31'd0, jogando}, {31'd0, lvl});
    endtask

    task automatic wait_botoes(input logic [3:0] v, input string name);
        int n = 0;
        while (botoes !== v && n < LIMIT) begin
            @(negedge clock);
            n++;
        end
        chk(name, {28'd0, botoes}, {28'd0, v});
    endtask

    task automatic finish_round(input string name);
        wait_jogando(1'b1, {name, " replay start"});
        wait_jogando(1'b0, {name, " replay end"});
        chk({name, " state after round"}, {28'd0, db_estado}, 32'd1);
        chk({name, " tamanho after round"}, {29'd0, tamanho}, 32'd0);
        chk({name, " all presses seen"}, exp_q.size(), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit saw_jog;
        int p;

        reset    = 1'b1;
        habilita = 1'b0;
        fim_jogo = 1'b0;
        leds     = 4'b0000;
        repeat (2) @(negedge clock);
        chk("reset botoes",  {28'd0, botoes},    32'd0);
        chk("reset jogando", {31'd0, jogando},   32'd0);
        chk("reset tamanho", {29'd0, tamanho},   32'd0);
        chk("reset erro",    {31'd0, erro_padrao}, 32'd0);
        chk("reset estouro", {31'd0, estouro},   32'd0);
        chk("reset estado",  {28'd0, db_estado}, 32'd0);
        reset = 1'b0;

        // Three one-hot LEDs, each held 2 cycles with 2-cycle gaps.
        restart();
        exp_q.push_back(4'b0001);
        exp_q.push_back(4'b0010);
        exp_q.push_back(4'b0100);
        cyc(4'b0001); cyc(4'b0001); cyc(4'b0000); cyc(4'b0000);
        cyc(4'b0010); cyc(4'b0010); cyc(4'b0000); cyc(4'b0000);
        cyc(4'b0100); cyc(4'b0100); cyc(4'b0000); cyc(4'b0000);
        chk("seq3 tamanho", {29'd0, tamanho}, 32'd3);
        chk("seq3 estouro", {31'd0, estouro}, 32'd0);
        chk("seq3 erro",    {31'd0, erro_padrao}, 32'd0);
        finish_round("seq3");

        // Invalid pattern, then a valid one.
        restart();
        exp_q.push_back(4'b1000);
        cyc(4'b0011); cyc(4'b0011); cyc(4'b0000); cyc(4'b0000);
        cyc(4'b1000); cyc(4'b1000); cyc(4'b0000); cyc(4'b0000);
        chk("badpat erro",    {31'd0, erro_padrao}, 32'd1);
        chk("badpat tamanho", {29'd0, tamanho}, 32'd1);
        finish_round("badpat");

        // Five LEDs into a four-entry buffer.
        restart();
        exp_q.push_back(4'b0001);
        exp_q.push_back(4'b0010);
        exp_q.push_back(4'b0100);
        exp_q.push_back(4'b1000);
        cyc(4'b0001); cyc(4'b0000);
        cyc(4'b0010); cyc(4'b0000);
        cyc(4'b0100); cyc(4'b0000);
        cyc(4'b1000); cyc(4'b0000);
        cyc(4'b0001); cyc(4'b0000); cyc(4'b0000);
        chk("overflow estouro", {31'd0, estouro}, 32'd1);
        chk("overflow tamanho", {29'd0, tamanho}, 32'd4);
        finish_round("overflow");

        // Same LED twice separated by a gap shorter than the quiet window.
        restart();
        exp_q.push_back(4'b1000);
        exp_q.push_back(4'b1000);
        saw_jog = 1'b0;
        cyc(4'b1000);
        for (int i = 0; i < 4; i++) begin
            cyc(4'b0000);
            saw_jog = saw_jog | jogando;
        end
        cyc(4'b1000);
        saw_jog = saw_jog | jogando;
        cyc(4'b0000); cyc(4'b0000);
        chk("short gap no replay", {31'd0, saw_jog}, 32'd0);
        chk("short gap tamanho", {29'd0, tamanho}, 32'd2);
        finish_round("shortgap");

        // Game ends during the second press.
        restart();
        exp_q.push_back(4'b0001);
        exp_q.push_back(4'b0010);
        cyc(4'b0001); cyc(4'b0000); cyc(4'b0010); cyc(4'b0000);
        wait_botoes(4'b0010, "fim second press");
        fim_jogo = 1'b1;
        @(negedge clock);
        chk("fim botoes",  {28'd0, botoes},    32'd0);
        chk("fim estado",  {28'd0, db_estado}, 32'd0);
        chk("fim jogando", {31'd0, jogando},   32'd0);
        repeat (2) @(negedge clock);
        fim_jogo = 1'b0;
        p = n_press;
        repeat (30) @(negedge clock);
        chk("fim no more presses", n_press, p);
        chk("fim back to wait", {28'd0, db_estado}, 32'd1);
        chk("fim queue drained", exp_q.size(), 32'd0);

        // Asynchronous reset in the middle of a press.
        restart();
        exp_q.push_back(4'b0100);
        cyc(4'b0100); cyc(4'b0000);
        wait_botoes(4'b0100, "rst press seen");
        #2;
        reset    = 1'b1;
        habilita = 1'b0;
        #1;
        chk("rst botoes",  {28'd0, botoes},    32'd0);
        chk("rst estado",  {28'd0, db_estado}, 32'd0);
        chk("rst tamanho", {29'd0, tamanho},   32'd0);
        chk("rst jogando", {31'd0, jogando},   32'd0);
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        habilita = 1'b1;
        @(negedge clock);
        chk("rst then enable", {28'd0, db_estado}, 32'd1);
        chk("rst queue drained", exp_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
